// File: rtl/neighbor_table_update_pkg.sv
// rtl/neighbor_table_update_pkg.sv - node memory map constants and neighbor table update types
package neighbor_table_update_pkg;

  // Neighbor table capacity and table base addresses in node memory
  localparam int          NODE_MAX_NEIGHBORS = 64;
  localparam logic [15:0] NODE_NID_BASE      = 16'h0048;
  localparam logic [15:0] NODE_CID_BASE      = 16'h00C8;
  localparam logic [15:0] NODE_BAT_BASE      = 16'h0148;
  localparam logic [15:0] NODE_QV_BASE       = 16'h01C8;
  localparam logic [15:0] NODE_NCNT_ADDR     = 16'h068A;

  typedef enum logic [1:0] {
    STATUS_UPDATED  = 2'b00,
    STATUS_APPENDED = 2'b01,
    STATUS_DROPPED  = 2'b10
  } upd_status_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_CNT,
    S_SEARCH,
    S_WR_ID,
    S_WR_CLU,
    S_WR_BAT,
    S_WR_Q,
    S_WR_CNT,
    S_DONE
  } upd_state_t;

  // Byte address of 16-bit entry idx in the table starting at base
  function automatic logic [15:0] entry_addr(input logic [15:0] base, input logic [6:0] idx);
    return base + {8'd0, idx, 1'b0};
  endfunction

endpackage

// File: rtl/neighbor_table_update_if.sv
// rtl/neighbor_table_update_if.sv - beacon record and memory port bundle for neighbor_table_update
interface neighbor_table_update_if;

  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] upd_id;
  logic [15:0] upd_cluster;
  logic [15:0] upd_battery;
  logic [15:0] upd_qvalue;

  logic        mem_gnt;
  logic        mem_req;
  logic [15:0] mem_address;
  logic        mem_wr_en;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic        done;
  logic [1:0]  status;
  logic [5:0]  entry_idx;

  // Table updater side
  modport slave (
    input  upd_valid, upd_id, upd_cluster, upd_battery, upd_qvalue,
    input  mem_gnt, mem_rdata,
    output upd_ready, mem_req, mem_address, mem_wr_en, mem_wdata,
    output done, status, entry_idx
  );

  // Parser / memory / arbiter side
  modport master (
    output upd_valid, upd_id, upd_cluster, upd_battery, upd_qvalue,
    output mem_gnt, mem_rdata,
    input  upd_ready, mem_req, mem_address, mem_wr_en, mem_wdata,
    input  done, status, entry_idx
  );

endinterface

// File: rtl/neighbor_table_update.sv
// rtl/neighbor_table_update.sv - look up a beacon's neighbor ID and update or append its table entry
module neighbor_table_update
  import neighbor_table_update_pkg::*;
#(
  parameter int          MAX_NEIGHBORS = NODE_MAX_NEIGHBORS,
  parameter logic [15:0] NID_BASE      = NODE_NID_BASE,
  parameter logic [15:0] CID_BASE      = NODE_CID_BASE,
  parameter logic [15:0] BAT_BASE      = NODE_BAT_BASE,
  parameter logic [15:0] QV_BASE       = NODE_QV_BASE,
  parameter logic [15:0] NCNT_ADDR     = NODE_NCNT_ADDR
) (
  input  logic                  clock,
  input  logic                  nrst,
  neighbor_table_update_if.slave bus
);

  // Count and index need one bit beyond the entry index to represent a full table
  localparam logic [6:0] MAX_CNT  = 7'(MAX_NEIGHBORS);
  localparam logic [5:0] LAST_IDX = 6'(MAX_NEIGHBORS - 1);

  upd_state_t  state;
  logic [15:0] id_q;
  logic [15:0] cluster_q;
  logic [15:0] battery_q;
  logic [15:0] qvalue_q;
  logic [6:0]  cnt_q;
  logic [6:0]  idx_q;
  logic        append_q;
  logic        full_seen_q;
  logic        upd_ready_q;
  logic        done_q;
  logic [1:0]  status_q;
  logic [5:0]  entry_idx_q;

  logic [15:0] addr_d;
  logic [15:0] wdata_d;
  logic        wr_state;
  logic [6:0]  sat_cnt;

  // A corrupt count word larger than the table is treated as a full table
  assign sat_cnt = (bus.mem_rdata > 16'(MAX_NEIGHBORS)) ? MAX_CNT : bus.mem_rdata[6:0];

  // Port address, write data and write intent are decoded from held state, so they stay put across stalls
  always_comb begin
    addr_d   = '0;
    wdata_d  = '0;
    wr_state = 1'b0;
    unique case (state)
      S_RD_CNT: addr_d = NCNT_ADDR;
      S_SEARCH: addr_d = entry_addr(NID_BASE, idx_q);
      S_WR_ID: begin
        addr_d   = entry_addr(NID_BASE, idx_q);
        wdata_d  = id_q;
        wr_state = 1'b1;
      end
      S_WR_CLU: begin
        addr_d   = entry_addr(CID_BASE, idx_q);
        wdata_d  = cluster_q;
        wr_state = 1'b1;
      end
      S_WR_BAT: begin
        addr_d   = entry_addr(BAT_BASE, idx_q);
        wdata_d  = battery_q;
        wr_state = 1'b1;
      end
      S_WR_Q: begin
        addr_d   = entry_addr(QV_BASE, idx_q);
        wdata_d  = qvalue_q;
        wr_state = 1'b1;
      end
      S_WR_CNT: begin
        addr_d   = NCNT_ADDR;
        wdata_d  = {9'd0, cnt_q + 7'd1};
        wr_state = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.upd_ready   = upd_ready_q;
  assign bus.mem_req     = (state != S_IDLE) && (state != S_DONE);
  assign bus.mem_address = addr_d;
  assign bus.mem_wdata   = wdata_d;
  assign bus.mem_wr_en   = wr_state && bus.mem_gnt;
  assign bus.done        = done_q;
  assign bus.status      = status_q;
  assign bus.entry_idx   = entry_idx_q;

  // Control FSM: accept a record, read the count, scan IDs, then write the entry words
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state       <= S_IDLE;
      id_q        <= '0;
      cluster_q   <= '0;
      battery_q   <= '0;
      qvalue_q    <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      append_q    <= 1'b0;
      full_seen_q <= 1'b0;
      upd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      status_q    <= STATUS_UPDATED;
      entry_idx_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.upd_valid && upd_ready_q) begin
            id_q        <= bus.upd_id;
            cluster_q   <= bus.upd_cluster;
            battery_q   <= bus.upd_battery;
            qvalue_q    <= bus.upd_qvalue;
            upd_ready_q <= 1'b0;
            state       <= S_RD_CNT;
          end
        end
        S_DONE: begin
          done_q      <= 1'b0;
          upd_ready_q <= 1'b1;
          state       <= S_IDLE;
        end
        default: begin
          if (bus.mem_gnt) begin
            case (state)
              S_RD_CNT: begin
                cnt_q       <= sat_cnt;
                idx_q       <= '0;
                full_seen_q <= 1'b0;
                state       <= S_SEARCH;
              end
              S_SEARCH: begin
                if (idx_q < cnt_q) begin
                  if (bus.mem_rdata == id_q) begin
                    status_q    <= STATUS_UPDATED;
                    entry_idx_q <= idx_q[5:0];
                    append_q    <= 1'b0;
                    state       <= S_WR_CLU;
                  end else begin
                    idx_q <= idx_q + 7'd1;
                  end
                end else if (cnt_q == MAX_CNT) begin
                  // The full-table verdict is held one extra cycle before reporting the drop
                  if (full_seen_q) begin
                    status_q    <= STATUS_DROPPED;
                    entry_idx_q <= LAST_IDX;
                    done_q      <= 1'b1;
                    state       <= S_DONE;
                  end else begin
                    full_seen_q <= 1'b1;
                  end
                end else begin
                  status_q    <= STATUS_APPENDED;
                  entry_idx_q <= idx_q[5:0];
                  append_q    <= 1'b1;
                  state       <= S_WR_ID;
                end
              end
              S_WR_ID:  state <= S_WR_CLU;
              S_WR_CLU: state <= S_WR_BAT;
              S_WR_BAT: state <= S_WR_Q;
              S_WR_Q: begin
                if (append_q) begin
                  state <= S_WR_CNT;
                end else begin
                  done_q <= 1'b1;
                  state  <= S_DONE;
                end
              end
              S_WR_CNT: begin
                done_q <= 1'b1;
                state  <= S_DONE;
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neighbor_table_update.sv
// tb/tb_neighbor_table_update.sv - scoreboard bench for neighbor_table_update
module tb_neighbor_table_update;
  import neighbor_table_update_pkg::*;

  typedef struct {
    logic [1:0] status;
    logic [5:0] idx;
    int         lat;
  } resp_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clock = 1'b0;
  logic nrst  = 1'b0;
  always #5 clock = ~clock;

  neighbor_table_update_if bus ();

  neighbor_table_update dut (
    .clock (clock),
    .nrst  (nrst),
    .bus   (bus.slave)
  );

  // Behavioural node memory: combinational read, posedge write
  logic [15:0] mem [0:1023];
  assign bus.mem_rdata = mem[bus.mem_address[10:1]];
  always @(posedge clock) if (bus.mem_wr_en) mem[bus.mem_address[10:1]] = bus.mem_wdata;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Grant: 0 = always granted, 1 = random, 2 = scripted
  int   gnt_mode   = 0;
  logic gnt_script = 1'b1;
  logic gnt_q      = 1'b1;
  assign bus.mem_gnt = gnt_q;
  always @(posedge clock) begin
    #2;
    case (gnt_mode)
      1:       gnt_q = ($urandom_range(3) != 0);
      2:       gnt_q = gnt_script;
      default: gnt_q = 1'b1;
    endcase
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Reference model of the tables
  logic [15:0] m_id  [64];
  logic [15:0] m_clu [64];
  logic [15:0] m_bat [64];
  logic [15:0] m_qv  [64];
  int          m_cnt_raw;

  resp_t exp_resp [$];
  wr_t   exp_wr   [$];

  function automatic int widx(input logic [15:0] addr);
    return int'(addr) >> 1;
  endfunction

  task automatic set_count(input int w);
    mem[widx(NODE_NCNT_ADDR)] = 16'(w);
    m_cnt_raw = w;
  endtask

  task automatic set_entry(input int i, input logic [15:0] id);
    mem[widx(NODE_NID_BASE) + i] = id;
    m_id[i] = id;
  endtask

  task automatic push_wr(input int addr, input logic [15:0] data);
    wr_t w;
    w.addr = 16'(addr);
    w.data = data;
    exp_wr.push_back(w);
  endtask

  task automatic model_apply(input logic [15:0] id, input logic [15:0] clu,
                             input logic [15:0] bat, input logic [15:0] qv);
    resp_t r;
    int cnt;
    int k;
    cnt = (m_cnt_raw > 64) ? 64 : m_cnt_raw;
    k = -1;
    for (int i = 0; i < cnt; i++) if (k < 0 && m_id[i] == id) k = i;
    if (k >= 0) begin
      r.status = 2'b00; r.idx = 6'(k); r.lat = 5 + k;
      push_wr(int'(NODE_CID_BASE) + 2 * k, clu);
      push_wr(int'(NODE_BAT_BASE) + 2 * k, bat);
      push_wr(int'(NODE_QV_BASE) + 2 * k, qv);
      m_clu[k] = clu; m_bat[k] = bat; m_qv[k] = qv;
    end else if (cnt == 64) begin
      r.status = 2'b10; r.idx = 6'd63; r.lat = 3 + 64;
    end else begin
      r.status = 2'b01; r.idx = 6'(cnt); r.lat = 7 + cnt;
      push_wr(int'(NODE_NID_BASE) + 2 * cnt, id);
      push_wr(int'(NODE_CID_BASE) + 2 * cnt, clu);
      push_wr(int'(NODE_BAT_BASE) + 2 * cnt, bat);
      push_wr(int'(NODE_QV_BASE) + 2 * cnt, qv);
      push_wr(int'(NODE_NCNT_ADDR), 16'(cnt + 1));
      m_id[cnt] = id; m_clu[cnt] = clu; m_bat[cnt] = bat; m_qv[cnt] = qv;
      m_cnt_raw = cnt + 1;
    end
    exp_resp.push_back(r);
  endtask

  // Monitor state shared with the driver
  bit          in_flight  = 1'b0;
  int          acc_cyc    = 0;
  int          stall_cnt  = 0;
  int          last_lat   = 0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_addr  = '0;
  logic [15:0] prev_wdata = '0;
  resp_t       r_got;
  wr_t         w_got;
  int          lat_act;

  always @(negedge clock) begin
    if (nrst) begin
      if (bus.mem_wr_en) begin
        chk("wr_gated", bus.mem_gnt, 1);
        chk("wr_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          w_got = exp_wr.pop_front();
          chk("wr_addr", bus.mem_address, w_got.addr);
          chk("wr_data", bus.mem_wdata, w_got.data);
        end
      end
      if (bus.done) begin
        chk("done_in_flight", in_flight, 1);
        if (in_flight && exp_resp.size() != 0) begin
          r_got    = exp_resp.pop_front();
          lat_act  = cyc - acc_cyc;
          last_lat = lat_act;
          chk("status", bus.status, r_got.status);
          chk("entry_idx", bus.entry_idx, r_got.idx);
          chk("latency", lat_act, r_got.lat + stall_cnt);
          chk("writes_drained", exp_wr.size(), 0);
        end
        in_flight = 1'b0;
      end else if (in_flight) begin
        if (prev_stall) begin
          chk("stall_addr_hold", bus.mem_address, prev_addr);
          chk("stall_wdata_hold", bus.mem_wdata, prev_wdata);
        end
        if (!bus.mem_gnt) begin
          chk("stall_no_write", bus.mem_wr_en, 0);
          stall_cnt++;
        end
        chk("mem_req_busy", bus.mem_req, 1);
        prev_stall = !bus.mem_gnt;
        prev_addr  = bus.mem_address;
        prev_wdata = bus.mem_wdata;
      end
    end
  end

  task automatic send(input logic [15:0] id, input logic [15:0] clu,
                      input logic [15:0] bat, input logic [15:0] qv);
    int guard;
    model_apply(id, clu, bat, qv);
    guard = 0;
    @(negedge clock);
    while (!bus.upd_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    chk("ready_idle", bus.upd_ready, 1);
    bus.upd_valid   = 1'b1;
    bus.upd_id      = id;
    bus.upd_cluster = clu;
    bus.upd_battery = bat;
    bus.upd_qvalue  = qv;
    @(posedge clock);
    #1;
    bus.upd_valid   = 1'b0;
    bus.upd_id      = 16'($urandom);
    bus.upd_cluster = 16'($urandom);
    bus.upd_battery = 16'($urandom);
    bus.upd_qvalue  = 16'($urandom);
    acc_cyc    = cyc;
    stall_cnt  = 0;
    prev_stall = 1'b0;
    in_flight  = 1'b1;
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (in_flight && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    if (in_flight) begin
      chk("done_timeout", in_flight, 0);
      in_flight = 1'b0;
      exp_resp.delete();
      exp_wr.delete();
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_upd_ready", bus.upd_ready, 1);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_wr_en", bus.mem_wr_en, 0);
    chk("rst_mem_address", bus.mem_address, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_status", bus.status, 0);
    chk("rst_entry_idx", bus.entry_idx, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 64; i++) begin
      m_id[i] = '0; m_clu[i] = '0; m_bat[i] = '0; m_qv[i] = '0;
    end
    m_cnt_raw       = 0;
    bus.upd_valid   = 1'b0;
    bus.upd_id      = '0;
    bus.upd_cluster = '0;
    bus.upd_battery = '0;
    bus.upd_qvalue  = '0;
    nrst = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_outputs();
    @(posedge clock);
    #1 nrst = 1'b1;

    // Hit at index 2
    set_count(4);
    set_entry(0, 16'd1); set_entry(1, 16'd3); set_entry(2, 16'd4); set_entry(3, 16'd6);
    send(16'd4, 16'd2, 16'h0050, 16'h0520);
    wait_done();
    chk("hit_latency", last_lat, 7);
    chk("hit_count_word", mem[widx(16'h068A)], 4);
    chk("hit_battery_word", mem[widx(16'h014C)], 16'h0050);

    // Append at index 4
    send(16'd9, 16'd5, 16'h0033, 16'h0100);
    wait_done();
    chk("append_latency", last_lat, 11);
    chk("append_count_word", mem[widx(16'h068A)], 5);
    chk("append_id_word", mem[widx(16'h0050)], 9);

    // Append into an empty table
    set_count(0);
    send(16'd7, 16'd1, 16'h0011, 16'h0022);
    wait_done();
    chk("empty_latency", last_lat, 7);
    chk("empty_id_word", mem[widx(16'h0048)], 7);
    chk("empty_count_word", mem[widx(16'h068A)], 1);

    // Full table drop, with a sane and a corrupt count word
    set_count(64);
    for (int i = 0; i < 64; i++) set_entry(i, 16'(1000 + i));
    send(16'd200, 16'd1, 16'd2, 16'd3);
    wait_done();
    chk("drop_latency", last_lat, 67);
    chk("drop_count_word", mem[widx(16'h068A)], 64);
    set_count(16'h00FF);
    send(16'd200, 16'd1, 16'd2, 16'd3);
    wait_done();
    chk("drop_ff_latency", last_lat, 67);
    chk("drop_ff_count_word", mem[widx(16'h068A)], 16'h00FF);

    // Hit at index 3 with the grant withdrawn for three cycles during WR_BAT
    set_count(4);
    set_entry(0, 16'd1); set_entry(1, 16'd3); set_entry(2, 16'd4); set_entry(3, 16'd6);
    gnt_script = 1'b1;
    gnt_mode   = 2;
    send(16'd6, 16'h0077, 16'h0abc, 16'h0def);
    repeat (6) @(posedge clock);
    #1 gnt_script = 1'b0;
    repeat (3) @(posedge clock);
    #1 gnt_script = 1'b1;
    wait_done();
    gnt_mode = 0;
    chk("stall_latency", last_lat, 11);
    chk("stall_battery_word", mem[widx(16'h014E)], 16'h0abc);

    // Reset during WR_CLU of an append, then resend the same record
    set_count(2);
    set_entry(0, 16'd10); set_entry(1, 16'd11);
    send(16'd12, 16'h000A, 16'h000B, 16'h000C);
    repeat (5) @(posedge clock);
    #1 nrst = 1'b0;
    chk("rst_pending_writes", exp_wr.size(), 4);
    in_flight = 1'b0;
    exp_wr.delete();
    exp_resp.delete();
    m_cnt_raw = 2;
    @(negedge clock);
    check_reset_outputs();
    chk("rst_partial_id", mem[widx(16'h004C)], 12);
    chk("rst_count_kept", mem[widx(16'h068A)], 2);
    @(posedge clock);
    #1 nrst = 1'b1;
    send(16'd12, 16'h000A, 16'h000B, 16'h000C);
    wait_done();
    chk("resend_latency", last_lat, 9);
    chk("resend_count_word", mem[widx(16'h068A)], 3);

    // Random records against the model with a random grant
    gnt_mode = 1;
    begin
      int n;
      n = $urandom_range(6);
      set_count(n);
      for (int i = 0; i < n; i++) set_entry(i, 16'($urandom_range(12, 1)));
    end
    for (int t = 0; t < 30; t++) begin
      send(16'($urandom_range(12, 1)), 16'($urandom), 16'($urandom), 16'($urandom));
      wait_done();
    end
    gnt_mode = 0;
    chk("final_count_word", mem[widx(NODE_NCNT_ADDR)], 16'(m_cnt_raw));
    for (int i = 0; i < m_cnt_raw && i < 64; i++) begin
      chk("final_id", mem[widx(NODE_NID_BASE) + i], m_id[i]);
      chk("final_cluster", mem[widx(NODE_CID_BASE) + i], m_clu[i]);
      chk("final_battery", mem[widx(NODE_BAT_BASE) + i], m_bat[i]);
      chk("final_qvalue", mem[widx(NODE_QV_BASE) + i], m_qv[i]);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
